// File: rtl/mlp_weight_fetcher.sv
// Weight fetcher: issues Avalon reads through the external bridge, buffers returned words in a FIFO
// and hands them to the MLP datapath one per ack pulse. Define MLP_FETCH_STATS_EN to add stall_cycles_o.
module mlp_weight_fetcher #(
    parameter int INTERFACE_WIDTH_BITS = 128,
    parameter int NUM_BUFFER_ENTRIES   = 64,
    parameter int INTERFACE_ADDR_BITS  = 26
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start_i,
    input  logic [INTERFACE_ADDR_BITS-1:0]  base_addr_i,
    input  logic [15:0]                     num_words_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [INTERFACE_ADDR_BITS-1:0]  bus_address_o,
    output logic                            bus_read_o,
    input  logic                            bus_waitrequest_i,
    input  logic [INTERFACE_WIDTH_BITS-1:0] bus_readdata_i,
    input  logic                            bus_readdatavalid_i,
    output logic [INTERFACE_WIDTH_BITS-1:0] data_o,
    output logic                            ack_o
`ifdef MLP_FETCH_STATS_EN
    ,
    output logic [31:0]                     stall_cycles_o
`endif
);

    localparam int PtrBits = $clog2(NUM_BUFFER_ENTRIES);
    localparam int CntBits = PtrBits + 1;
    localparam logic [INTERFACE_ADDR_BITS-1:0] AddrStep = INTERFACE_ADDR_BITS'(INTERFACE_WIDTH_BITS / 8);
    localparam logic [CntBits:0]   Capacity  = (CntBits + 1)'(NUM_BUFFER_ENTRIES);
    localparam logic [CntBits-1:0] FullCount = CntBits'(NUM_BUFFER_ENTRIES);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                          state_q, state_d;
    logic [INTERFACE_ADDR_BITS-1:0]  addr_q, addr_d;
    logic [15:0]                     total_q, total_d;
    logic [15:0]                     issued_q, issued_d;
    logic [15:0]                     delivered_q, delivered_d;
    logic [CntBits-1:0]              outstanding_q, outstanding_d;
    logic [CntBits-1:0]              fifoCount_q, fifoCount_d;
    logic [PtrBits-1:0]              wrPtr_q, wrPtr_d;
    logic [PtrBits-1:0]              rdPtr_q, rdPtr_d;
    logic [INTERFACE_WIDTH_BITS-1:0] fifoMem_q [NUM_BUFFER_ENTRIES];
    logic [INTERFACE_WIDTH_BITS-1:0] data_q, data_d;
    logic                            ack_q, ack_d;

    logic active;
    logic canIssue;
    logic accept;
    logic retire;
    logic pushEn;
    logic popEn;

    // Reads in flight plus buffered words never exceed the FIFO depth, so every return has a slot.
    assign active   = (state_q != IDLE);
    assign canIssue = (state_q == FETCH) && (issued_q < total_q)
                      && (({1'b0, fifoCount_q} + {1'b0, outstanding_q}) < Capacity);
    assign accept   = canIssue && !bus_waitrequest_i;
    assign retire   = active && bus_readdatavalid_i && (outstanding_q != '0);
    assign pushEn   = active && bus_readdatavalid_i && (fifoCount_q != FullCount);
    assign popEn    = ((state_q == FETCH) || (state_q == DRAIN)) && (fifoCount_q != '0) && !ack_q;

    assign busy_o        = active;
    assign done_o        = (state_q == DONE);
    assign bus_read_o    = canIssue;
    assign bus_address_o = addr_q;
    assign data_o        = data_q;
    assign ack_o         = ack_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        total_d       = total_q;
        issued_d      = issued_q;
        delivered_d   = delivered_q;
        data_d        = data_q;
        ack_d         = 1'b0;
        outstanding_d = outstanding_q + CntBits'(accept) - CntBits'(retire);
        fifoCount_d   = fifoCount_q + CntBits'(pushEn) - CntBits'(popEn);
        wrPtr_d       = wrPtr_q + PtrBits'(pushEn);
        rdPtr_d       = rdPtr_q + PtrBits'(popEn);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    issued_d    = '0;
                    delivered_d = '0;
                    if (num_words_i != 16'd0) begin
                        addr_d  = base_addr_i;
                        total_d = num_words_i;
                        state_d = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FETCH: begin
                if (accept) begin
                    issued_d = issued_q + 16'd1;
                    addr_d   = addr_q + AddrStep;
                    if ((issued_q + 16'd1) == total_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((delivered_q == total_q) && !ack_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Gating on ack_q spaces acks at least two cycles apart to match the consumer's OUT cycle.
        if (popEn) begin
            data_d      = fifoMem_q[rdPtr_q];
            ack_d       = 1'b1;
            delivered_d = delivered_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            total_q       <= '0;
            issued_q      <= '0;
            delivered_q   <= '0;
            outstanding_q <= '0;
            fifoCount_q   <= '0;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            data_q        <= '0;
            ack_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            total_q       <= total_d;
            issued_q      <= issued_d;
            delivered_q   <= delivered_d;
            outstanding_q <= outstanding_d;
            fifoCount_q   <= fifoCount_d;
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            data_q        <= data_d;
            ack_q         <= ack_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pushEn) fifoMem_q[wrPtr_q] <= bus_readdata_i;
    end

`ifdef MLP_FETCH_STATS_EN
    logic [31:0] stallCycles_q, stallCycles_d;

    always_comb begin
        stallCycles_d = stallCycles_q;
        if ((state_q == IDLE) && start_i) begin
            stallCycles_d = '0;
        end else if (bus_read_o && bus_waitrequest_i && (stallCycles_q != 32'hFFFF_FFFF)) begin
            stallCycles_d = stallCycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) stallCycles_q <= '0;
        else        stallCycles_q <= stallCycles_d;
    end

    assign stall_cycles_o = stallCycles_q;
`endif

endmodule

// File: tb/tb_mlp_weight_fetcher.sv
// Scoreboard bench for mlp_weight_fetcher: a memory model answers bus reads with random stalls and
// latency, expected addresses and words are queued at each start and checked by an independent monitor.
module tb_mlp_weight_fetcher;

    localparam int W         = 128;
    localparam int N         = 64;
    localparam int AW        = 26;
    localparam int StepBytes = W / 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [15:0]   num_words_i = '0;
    logic          busy_o;
    logic          done_o;
    logic [AW-1:0] bus_address_o;
    logic          bus_read_o;
    logic          bus_waitrequest_i = 1'b0;
    logic [W-1:0]  bus_readdata_i = '0;
    logic          bus_readdatavalid_i = 1'b0;
    logic [W-1:0]  data_o;
    logic          ack_o;
`ifdef MLP_FETCH_STATS_EN
    logic [31:0]   stall_cycles_o;
`endif

    always #5 clk = ~clk;

    mlp_weight_fetcher #(
        .INTERFACE_WIDTH_BITS(W),
        .NUM_BUFFER_ENTRIES(N),
        .INTERFACE_ADDR_BITS(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_i(start_i),
        .base_addr_i(base_addr_i),
        .num_words_i(num_words_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .bus_address_o(bus_address_o),
        .bus_read_o(bus_read_o),
        .bus_waitrequest_i(bus_waitrequest_i),
        .bus_readdata_i(bus_readdata_i),
        .bus_readdatavalid_i(bus_readdatavalid_i),
        .data_o(data_o),
        .ack_o(ack_o)
`ifdef MLP_FETCH_STATS_EN
        , .stall_cycles_o(stall_cycles_o)
`endif
    );

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } pend_t;

    int            compared = 0;
    int            mismatched = 0;
    int            cycle = 0;
    logic [W-1:0]  expData[$];
    logic [AW-1:0] expAddr[$];
    pend_t         pendQ[$];
    int            fixedLat = 2;
    bit            randWait = 1'b0;
    logic [AW-1:0] stallAddr = '0;
    int            stallBudget = 0;
    int            lastDue = 0;
    int            accCount = 0;
    int            ackCount = 0;
    int            lastAckCycle = -100;
    int            stallModel = 0;
    int            doneCount = 0;
    bit            readSeen = 1'b0;

    // Memory contents are a fixed function of the byte address.
    function automatic logic [W-1:0] memWord(input logic [AW-1:0] a);
        logic [31:0] x;
        x = {6'd0, a};
        return {x * 32'h9E37_79B1, ~x, x ^ 32'h5A5A_5A5A, x + 32'h0123_4567};
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Bus responder: chooses waitrequest, records accepted reads and returns them in order.
    initial begin
        int lat;
        int due;
        forever begin
            @(negedge clk);
            if (pendQ.size() > 0 && pendQ[0].due <= cycle) begin
                bus_readdatavalid_i = 1'b1;
                bus_readdata_i      = memWord(pendQ[0].addr);
                void'(pendQ.pop_front());
            end else begin
                bus_readdatavalid_i = 1'b0;
                bus_readdata_i      = {4{$urandom}};
            end
            if (bus_read_o && stallBudget > 0 && bus_address_o == stallAddr) begin
                bus_waitrequest_i = 1'b1;
                stallBudget--;
            end else if (randWait) begin
                bus_waitrequest_i = ($urandom_range(0, 3) == 0);
            end else begin
                bus_waitrequest_i = 1'b0;
            end
            if (bus_read_o && !bus_waitrequest_i && reset) begin
                lat = (fixedLat > 0) ? fixedLat : int'($urandom_range(1, 6));
                due = cycle + lat;
                if (due <= lastDue) due = lastDue + 1;
                lastDue = due;
                pendQ.push_back('{bus_address_o, due});
            end
        end
    end

    // Monitor: checks read addresses, throttle, ack spacing and delivered data against the queues.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (ack_o && reset) begin
                ackCount++;
                checkOutput("ackSpacing", (cycle - lastAckCycle) >= 2, 1);
                lastAckCycle = cycle;
                if (expData.size() == 0) checkOutput("unexpectedAck", 1, 0);
                else                     checkOutput("ackData", data_o, expData.pop_front());
            end
            if (bus_read_o && reset) begin
                readSeen = 1'b1;
                if (expAddr.size() == 0) begin
                    checkOutput("unexpectedRead", bus_address_o, 0);
                end else begin
                    checkOutput("busAddress", bus_address_o, expAddr[0]);
                    if (!bus_waitrequest_i) begin
                        void'(expAddr.pop_front());
                        checkOutput("throttle", (accCount - ackCount) < N, 1);
                        accCount++;
                    end
                end
                if (bus_waitrequest_i) stallModel++;
            end
            if (done_o) doneCount++;
            if (!reset || (start_i && !busy_o)) begin
                accCount   = 0;
                ackCount   = 0;
                stallModel = 0;
                readSeen   = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input logic [AW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] a;
            a = base + AW'(i * StepBytes);
            expAddr.push_back(a);
            expData.push_back(memWord(a));
        end
        start_i     = 1'b1;
        base_addr_i = base;
        num_words_i = 16'(n);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic finishTransfer(input int budget, output int latency);
        int waited;
        waited = 0;
        while (!done_o && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        latency = waited + 1;
        if (!done_o) begin
            checkOutput("doneTimeout", 0, 1);
            expData.delete();
            expAddr.delete();
            return;
        end
        checkOutput("allDelivered", expData.size(), 0);
        checkOutput("allIssued", expAddr.size(), 0);
        checkOutput("busyAtDone", busy_o, 1);
`ifdef MLP_FETCH_STATS_EN
        checkOutput("stallCount", stall_cycles_o, stallModel);
`endif
        @(negedge clk);
        checkOutput("busyAfterDone", busy_o, 0);
        checkOutput("donePulseWidth", done_o, 0);
    endtask

    task automatic checkResetState();
        checkOutput("rstBusy", busy_o, 0);
        checkOutput("rstDone", done_o, 0);
        checkOutput("rstRead", bus_read_o, 0);
        checkOutput("rstAddr", bus_address_o, 0);
        checkOutput("rstData", data_o, 0);
        checkOutput("rstAck", ack_o, 0);
`ifdef MLP_FETCH_STATS_EN
        checkOutput("rstStall", stall_cycles_o, 0);
`endif
    endtask

    initial begin
        int lat;
        int waited;
        int doneBefore;
        logic [AW-1:0] base;

        repeat (3) @(negedge clk);
        checkResetState();
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] basic fetch");
        applyStimulus(26'h100, 4);
        finishTransfer(200, lat);

        $display("[TB] stall on second request");
        stallAddr   = 26'h110;
        stallBudget = 3;
        applyStimulus(26'h100, 4);
        finishTransfer(200, lat);
`ifdef MLP_FETCH_STATS_EN
        checkOutput("stallThree", stall_cycles_o, 3);
`endif

        $display("[TB] backpressure with full buffer");
        applyStimulus(26'h1000, 100);
        finishTransfer(3000, lat);

        $display("[TB] zero length");
        applyStimulus(26'h2000, 0);
        finishTransfer(20, lat);
        checkOutput("zeroLatency", (lat >= 1) && (lat <= 2), 1);
        checkOutput("zeroRead", readSeen, 0);
        checkOutput("zeroAck", ackCount, 0);

        $display("[TB] start while busy");
        applyStimulus(26'h200, 10);
        repeat (3) @(negedge clk);
        start_i     = 1'b1;
        base_addr_i = 26'h800;
        num_words_i = 16'd3;
        @(negedge clk);
        start_i = 1'b0;
        finishTransfer(500, lat);
        doneBefore = doneCount;
        repeat (20) @(negedge clk);
        checkOutput("ignoredStartDone", doneCount - doneBefore, 0);
        checkOutput("ignoredStartBusy", busy_o, 0);

        $display("[TB] randomized transfers");
        randWait = 1'b1;
        fixedLat = 0;
        for (int t = 0; t < 6; t++) begin
            base = AW'($urandom) & ~AW'(StepBytes - 1);
            applyStimulus(base, $urandom_range(1, 40));
            finishTransfer(2000, lat);
        end
        applyStimulus(26'h3FF_FFE0, 5);
        finishTransfer(500, lat);

        $display("[TB] reset mid-transfer");
        randWait = 1'b0;
        fixedLat = 4;
        applyStimulus(26'h400, 8);
        waited = 0;
        while (ackCount < 2 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("twoAcksBeforeReset", ackCount >= 2, 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        expData.delete();
        expAddr.delete();
        checkResetState();
        waited = 0;
        while (pendQ.size() > 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        repeat (4) @(negedge clk);
        checkOutput("lateDataAck", ackCount, 0);
        checkOutput("idleAfterLate", busy_o, 0);
        fixedLat = 2;
        applyStimulus(26'h40, 2);
        finishTransfer(200, lat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
